// File: rtl/mixcol_fwd_seq.sv
// ---------------------------------------------------------------------------
// mixcol_fwd_seq
//   Forward AES MixColumns engine, sequential over the four state columns.
//   Accepts one 128-bit state per handshake, mixes COLS_PER_CYCLE columns per
//   clock in place in a working register, then presents the mixed state.
//   in_bypass (final round) passes the state through unmixed with identical
//   timing.
//
// Parameters
//   COLS_PER_CYCLE  columns mixed per clock: 1, 2 or 4
//
// Ports
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    in_data/in_bypass valid
//   in_ready   out  1    block accepts a state this cycle
//   in_data    in   128  state; column c = in_data[127-32c -: 32], row 0 = MSB
//   in_bypass  in   1    1: pass state through unmixed
//   out_valid  out  1    out_data valid
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  mixed state, same byte ordering as in_data
//   busy       out  1    high while columns are being mixed
// ---------------------------------------------------------------------------
module mixcol_fwd_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mixcol_fwd_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  // GF(2^8) multiply by 2, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] t0, t1, t2, t3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    t0 = xtime(a0);
    t1 = xtime(a1);
    t2 = xtime(a2);
    t3 = xtime(a3);
    mix_col = {t0 ^ t1 ^ a1 ^ a2 ^ a3,
               a0 ^ t1 ^ t2 ^ a2 ^ a3,
               a0 ^ a1 ^ t2 ^ t3 ^ a3,
               t0 ^ a0 ^ a1 ^ a2 ^ t3};
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0][31:0] r_work;
  logic            r_bypass;
  logic [1:0]      r_cnt;
  logic [2:0]      w_cnt_sum;
  logic            w_last;
  logic            w_accept;
  logic [1:0]      w_idx   [COLS_PER_CYCLE];
  logic [31:0]     w_mixed [COLS_PER_CYCLE];

  // Counter only ever holds multiples of COLS_PER_CYCLE, so reaching 4 is
  // exactly the carry out of the 2-bit counter.
  assign w_cnt_sum = {1'b0, r_cnt} + STEP;
  assign w_last    = w_cnt_sum[2];
  assign w_accept  = in_valid & in_ready;

  // Column c lives in packed element 3-c (column 0 is the MSB word), and
  // 3-c on two bits is simply ~c.
  generate
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
      assign w_idx[k]   = r_cnt + 2'(k);
      assign w_mixed[k] = mix_col(r_work[~w_idx[k]]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_BUSY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (r_state == S_DONE) out_data = r_work;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_bypass <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_work   <= in_data;
      r_bypass <= in_bypass;
      r_cnt    <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= w_cnt_sum[1:0];
      if (!r_bypass) begin
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
          r_work[~w_idx[k]] <= w_mixed[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_mixcol_fwd_seq.sv
module tb_mixcol_fwd_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic         in_bypass;
  logic [2:0]   iv, ordy, ir, ov, bz;
  logic [127:0] od [3];

  int n_chk  = 0;
  int n_fail = 0;
  logic [127:0] sb [$];

  always #5 clk = ~clk;

  mixcol_fwd_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]));

  mixcol_fwd_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]));

  mixcol_fwd_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data), .in_bypass(in_bypass), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(od[2]), .busy(bz[2]));

  localparam logic [127:0] APPB_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] APPB_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] ID_IN    = 128'hc6c6c6c6_f20a225c_2d26314c_01010101;
  localparam logic [127:0] ID_OUT   = 128'hc6c6c6c6_9fdc589d_4d7ebdf8_01010101;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];
  int   cpcs [3] = '{1, 2, 4};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a state on instance d and push its expected result once accepted.
  task automatic send(input int d, input logic [127:0] din, input logic byp,
                      input logic [127:0] exp, input string name);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_data   = din;
    in_bypass = byp;
    iv[d]     = 1'b1;
    while (!acc && n < 20) begin
      acc = iv[d] & ir[d];
      @(posedge clk); #1;
      n++;
    end
    iv[d] = 1'b0;
    if (acc) sb.push_back(exp);
    else chk({name, " accept"}, 128'(0), 128'(1));
  endtask

  // Wait (bounded) for out_valid on instance d; compare latency and data.
  task automatic wait_out(input int d, input int exp_lat, input string name);
    int lat;
    lat = 0;
    while (!ov[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 128'(lat), 128'(exp_lat));
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 128'(0), 128'(1));
    end else if (ov[d]) begin
      chk({name, " data"}, od[d], sb.pop_front());
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    vecs[0] = '{"single col", 128'hdb135345_01010101_01010101_01010101, 1'b0,
                128'h8e4da1bc_01010101_01010101_01010101};
    vecs[1] = '{"fips appB", APPB_IN, 1'b0, APPB_OUT};
    vecs[2] = '{"identity cols", ID_IN, 1'b0, ID_OUT};
    vecs[3] = '{"bypass", APPB_IN, 1'b1, APPB_IN};

    rst_n     = 1'b0;
    in_data   = '0;
    in_bypass = 1'b0;
    iv        = '0;
    ordy      = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset out_valid c%0d", cpcs[d]), 128'(ov[d]), 128'(0));
      chk($sformatf("reset out_data c%0d", cpcs[d]), od[d], 128'(0));
      chk($sformatf("reset busy c%0d", cpcs[d]), 128'(bz[d]), 128'(0));
      chk($sformatf("reset in_ready c%0d", cpcs[d]), 128'(ir[d]), 128'(1));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors on every width
    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 4; v++) begin
        string nm;
        nm = $sformatf("%s c%0d", vecs[v].name, cpcs[d]);
        ordy[d] = 1'b1;
        send(d, vecs[v].din, vecs[v].byp, vecs[v].exp, nm);
        wait_out(d, 4 / cpcs[d], nm);
        @(posedge clk); #1;
        chk({nm, " drained"}, 128'(ov[d]), 128'(0));
        ordy[d] = 1'b0;
      end
    end

    // Backpressure then back-to-back on the single-column instance
    ordy[0] = 1'b0;
    send(0, APPB_IN, 1'b0, APPB_OUT, "bp first");
    wait_out(0, 4, "bp first");
    in_data   = ID_IN;
    in_bypass = 1'b0;
    iv[0]     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold data %0d", i), od[0], APPB_OUT);
      chk($sformatf("bp hold in_ready %0d", i), 128'(ir[0]), 128'(0));
      chk($sformatf("bp hold out_valid %0d", i), 128'(ov[0]), 128'(1));
    end
    ordy[0] = 1'b1;
    #1;
    chk("b2b in_ready follows out_ready", 128'(ir[0]), 128'(1));
    @(posedge clk); #1;
    sb.push_back(ID_OUT);
    iv[0] = 1'b0;
    chk("b2b no bubble busy", 128'(bz[0]), 128'(1));
    chk("b2b out_valid dropped", 128'(ov[0]), 128'(0));
    wait_out(0, 4, "b2b second");
    @(posedge clk); #1;
    chk("b2b drained", 128'(ov[0]), 128'(0));

    // Reset two clocks into BUSY
    ordy[0] = 1'b1;
    send(0, APPB_IN, 1'b0, APPB_OUT, "rst mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rst mid out_valid", 128'(ov[0]), 128'(0));
    chk("rst mid out_data", od[0], 128'(0));
    chk("rst mid busy", 128'(bz[0]), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, ID_IN, 1'b0, ID_OUT, "after rst");
    wait_out(0, 4, "after rst");
    @(posedge clk); #1;
    chk("after rst drained", 128'(ov[0]), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
